// File: rtl/z80_bus_mem_bridge_if.sv
// Signal bundle between a tv80s-style Z80 bus, a req/ack memory port and the write log.
// The bridge is the slave; the CPU/memory/log environment is the master.
interface z80_bus_mem_bridge_if;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic        cpu_m1_n;
  logic        cpu_rfsh_n;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic        log_valid;
  logic        log_ready;
  logic [24:0] log_data;
  logic        log_overflow;
  logic        bus_timeout;

  modport master (
    output cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n,
    output mem_ack, mem_rdata, log_ready,
    input  cpu_di, cpu_wait_n, mem_req, mem_we, mem_addr, mem_wdata,
    input  log_valid, log_data, log_overflow, bus_timeout
  );

  modport slave (
    input  cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n,
    input  mem_ack, mem_rdata, log_ready,
    output cpu_di, cpu_wait_n, mem_req, mem_we, mem_addr, mem_wdata,
    output log_valid, log_data, log_overflow, bus_timeout
  );
endinterface

// File: rtl/z80_bus_mem_bridge.sv
// Converts Z80 bus strobes into a req/ack memory transaction, stalling the CPU until ack or
// timeout, and records every completed write in a small FIFO for bus-traffic inspection.
module z80_bus_mem_bridge #(
  parameter logic [7:0]  IO_PAGE   = 8'h10,
  parameter int unsigned WAIT_MAX  = 16,
  parameter int unsigned LOG_DEPTH = 8
) (
  input logic                clk,
  input logic                reset,
  z80_bus_mem_bridge_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   wait_cnt_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic               is_io_q;
  logic [15:0]        mem_addr_q;
  logic [7:0]         mem_wdata_q;
  logic [7:0]         cpu_di_q;
  logic               bus_timeout_q;

  logic [24:0]        log_mem_q [LOG_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               log_overflow_q, log_overflow_d;

  logic access, io_cycle, int_ack, done;
  logic push, pop, full, push_ok;

  // Refresh cycles and interrupt acknowledge never reach memory.
  assign access   = bus.cpu_rfsh_n
                  & (~bus.cpu_mreq_n | (~bus.cpu_iorq_n & bus.cpu_m1_n))
                  & (~bus.cpu_rd_n | ~bus.cpu_wr_n);
  assign io_cycle = ~bus.cpu_iorq_n & bus.cpu_mreq_n;
  assign int_ack  = ~bus.cpu_iorq_n & ~bus.cpu_m1_n;
  assign done     = (state_q == S_DONE);

  assign bus.cpu_wait_n = reset | ~(access & ~done);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      is_io_q       <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_di_q      <= 8'hFF;
      bus_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (access) begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= ~bus.cpu_wr_n;
            is_io_q     <= io_cycle;
            mem_addr_q  <= io_cycle ? {IO_PAGE, bus.cpu_a[7:0]} : bus.cpu_a;
            mem_wdata_q <= bus.cpu_dout;
            wait_cnt_q  <= '0;
          end else if (int_ack) begin
            cpu_di_q <= 8'hFF;
          end
        end
        S_REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_DONE;
            if (!mem_we_q) cpu_di_q <= bus.mem_rdata;
          end else if (wait_cnt_q == CNT_W'(WAIT_MAX - 1)) begin
            mem_req_q     <= 1'b0;
            state_q       <= S_DONE;
            cpu_di_q      <= 8'hFF;
            bus_timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          // Hold off until the strobe drops so one strobe yields exactly one transaction.
          if (!access) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign full    = (count_q == (PTR_W + 1)'(LOG_DEPTH));
  assign push    = (state_q == S_REQ) & bus.mem_ack & mem_we_q;
  assign pop     = bus.log_ready & (count_q != '0);
  assign push_ok = push & (~full | pop);

  // NOTE: combinational next-state uses blocking assignments with a default for every
  // target first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    log_overflow_d = log_overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    if (push && !push_ok) log_overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      log_overflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      log_overflow_q <= log_overflow_d;
    end
  end

  // NOTE: log storage has no reset; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) log_mem_q[wr_ptr_q] <= {is_io_q, mem_addr_q, mem_wdata_q};
  end

  assign bus.cpu_di       = cpu_di_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.log_valid    = (count_q != '0);
  assign bus.log_data     = log_mem_q[rd_ptr_q];
  assign bus.log_overflow = log_overflow_q;
  assign bus.bus_timeout  = bus_timeout_q;

endmodule

// File: tb/tb_z80_bus_mem_bridge.sv
// Directed and random bus cycles against z80_bus_mem_bridge, compared with a transaction-level
// model (reference memory, expected cpu_di, expected write-log queue and sticky flags).
module tb_z80_bus_mem_bridge;
  localparam logic [7:0] IO_PAGE   = 8'h10;
  localparam int         WAIT_MAX  = 16;
  localparam int         LOG_DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  z80_bus_mem_bridge_if bus ();

  z80_bus_mem_bridge #(
    .IO_PAGE  (IO_PAGE),
    .WAIT_MAX (WAIT_MAX),
    .LOG_DEPTH(LOG_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  ram     [65536];
  logic [7:0]  ref_mem [65536];
  logic [7:0]  exp_di;
  bit          exp_to;
  bit          exp_ovf;
  logic [24:0] exp_log [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_strobes();
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_rfsh_n = 1'b1;
  endtask

  // Outcome of one completed (or aborted) access on the expected architectural state.
  function automatic void model_txn(input bit is_io, input bit is_wr, input logic [15:0] a,
                                    input logic [7:0] d, input bit acked);
    logic [15:0] ea;
    ea = is_io ? {IO_PAGE, a[7:0]} : a;
    if (!acked) begin
      exp_to = 1'b1;
      exp_di = 8'hFF;
    end else if (is_wr) begin
      ref_mem[ea] = d;
      if (exp_log.size() < LOG_DEPTH) exp_log.push_back({is_io, ea, d});
      else exp_ovf = 1'b1;
    end else begin
      exp_di = ref_mem[ea];
    end
  endfunction

  // lat = REQ cycle in which memory acks (0 = never); release_after = REQ cycle after which the
  // CPU drops its strobe (0 = hold); pop_on_ack = pop the log in the same cycle as the ack.
  task automatic bus_cycle(input bit is_io, input bit is_wr, input logic [15:0] a,
                           input logic [7:0] d, input int lat, input int release_after,
                           input bit pop_on_ack);
    logic [15:0] ea;
    int          waits, reqs, exp_reqs;
    bit          finished, held;
    ea       = is_io ? {IO_PAGE, a[7:0]} : a;
    waits    = 0;
    reqs     = 0;
    finished = 1'b0;
    held     = 1'b1;
    exp_reqs = (lat == 0) ? WAIT_MAX : lat;
    @(negedge clk);
    bus.cpu_a      = a;
    bus.cpu_dout   = d;
    bus.cpu_mreq_n = is_io;
    bus.cpu_iorq_n = ~is_io;
    bus.cpu_rd_n   = is_wr;
    bus.cpu_wr_n   = ~is_wr;
    bus.cpu_m1_n   = 1'b1;
    bus.cpu_rfsh_n = 1'b1;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (bus.cpu_wait_n === 1'b0) waits++;
      if (bus.mem_req === 1'b1) begin
        reqs++;
        check("mem_addr", 32'(bus.mem_addr), 32'(ea));
        check("mem_we", 32'(bus.mem_we), 32'(is_wr));
        if (is_wr) check("mem_wdata", 32'(bus.mem_wdata), 32'(d));
        bus.mem_ack   = (lat != 0) && (reqs == lat);
        bus.mem_rdata = ram[bus.mem_addr];
        if (bus.mem_ack && bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
        if (pop_on_ack) begin
          bus.log_ready = bus.mem_ack;
          if (bus.mem_ack && exp_log.size() > 0) begin
            check("pop_head", 32'(bus.log_data), 32'(exp_log[0]));
            void'(exp_log.pop_front());
          end
        end
        if (release_after != 0 && reqs == release_after) begin
          idle_strobes();
          held = 1'b0;
        end
      end else if (reqs > 0) begin
        finished = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    if (pop_on_ack) bus.log_ready = 1'b0;
    check("finished", 32'(finished), 32'd1);
    model_txn(is_io, is_wr, a, d, lat != 0);
    check("req_cycles", 32'(reqs), 32'(exp_reqs));
    if (held) begin
      check("wait_n_resume", 32'(bus.cpu_wait_n), 32'd1);
      // Low in the strobe's first cycle plus one wait state per REQ cycle.
      check("wait_low", 32'(waits), 32'(exp_reqs + 1));
    end
    check("cpu_di", 32'(bus.cpu_di), 32'(exp_di));
    check("timeout", 32'(bus.bus_timeout), 32'(exp_to));
    check("overflow", 32'(bus.log_overflow), 32'(exp_ovf));
    check("log_valid", 32'(bus.log_valid), 32'(exp_log.size() != 0));
    @(negedge clk);
    idle_strobes();
    #1;
    check("idle_wait_n", 32'(bus.cpu_wait_n), 32'd1);
    check("idle_req", 32'(bus.mem_req), 32'd0);
  endtask

  task automatic drain_log();
    @(negedge clk);
    #1;
    while (exp_log.size() > 0) begin
      check("drain_valid", 32'(bus.log_valid), 32'd1);
      check("drain_data", 32'(bus.log_data), 32'(exp_log[0]));
      void'(exp_log.pop_front());
      bus.log_ready = 1'b1;
      @(negedge clk);
      #1;
    end
    bus.log_ready = 1'b0;
    check("drain_empty", 32'(bus.log_valid), 32'd0);
  endtask

  bit          r_io, r_wr;
  logic [15:0] r_a;
  logic [7:0]  r_d;
  int          r_lat;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[0]     = 8'hFD;
    ref_mem[0] = 8'hFD;
    idle_strobes();
    bus.cpu_a     = '0;
    bus.cpu_dout  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    bus.log_ready = 1'b0;
    exp_di  = 8'hFF;
    exp_to  = 1'b0;
    exp_ovf = 1'b0;

    // Reset state, with a read strobe present to show wait_n is forced high.
    repeat (3) @(negedge clk);
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    #1;
    check("rst_wait_n", 32'(bus.cpu_wait_n), 32'd1);
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_di", 32'(bus.cpu_di), 32'hFF);
    check("rst_log_valid", 32'(bus.log_valid), 32'd0);
    check("rst_overflow", 32'(bus.log_overflow), 32'd0);
    check("rst_timeout", 32'(bus.bus_timeout), 32'd0);
    idle_strobes();
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait read, IO write, slow write, timeout read.
    bus_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 1, 0, 1'b0);
    check("zw_di", 32'(bus.cpu_di), 32'hFD);
    bus_cycle(1'b1, 1'b1, 16'h0042, 8'h5A, 1, 0, 1'b0);
    check("io_log", 32'(bus.log_data), 32'({1'b1, 16'h1042, 8'h5A}));
    drain_log();
    bus_cycle(1'b0, 1'b1, 16'h2345, 8'hC3, 5, 0, 1'b0);
    drain_log();
    bus_cycle(1'b0, 1'b0, 16'h3000, 8'h00, 0, 0, 1'b0);
    check("to_flag", 32'(bus.bus_timeout), 32'd1);

    // Strobe dropped in the middle of REQ: the access still completes.
    bus_cycle(1'b0, 1'b1, 16'h2400, 8'h96, 3, 1, 1'b0);
    bus_cycle(1'b0, 1'b0, 16'h2345, 8'h00, 2, 1, 1'b0);
    drain_log();

    for (int t = 0; t < 24; t++) begin
      r_io  = 1'($urandom);
      r_wr  = 1'($urandom);
      r_a   = 16'($urandom_range(65535, 256));
      r_d   = 8'($urandom);
      r_lat = $urandom_range(4, 1);
      bus_cycle(r_io, r_wr, r_a, r_d, r_lat, 0, 1'b0);
      if (t % 4 == 3) drain_log();
    end
    drain_log();

    // Fill the log, pop+push while full, then one dropped write.
    for (int i = 0; i < LOG_DEPTH; i++)
      bus_cycle(1'b0, 1'b1, 16'h4000 + 16'(i), 8'h20 + 8'(i), 1, 0, 1'b0);
    bus_cycle(1'b0, 1'b1, 16'h4008, 8'h28, 1, 0, 1'b1);
    check("full_no_ovf", 32'(bus.log_overflow), 32'd0);
    bus_cycle(1'b0, 1'b1, 16'h4009, 8'h29, 1, 0, 1'b0);
    check("full_ovf", 32'(bus.log_overflow), 32'd1);
    drain_log();

    // Reset while a write waits in REQ.
    @(negedge clk);
    bus.cpu_a      = 16'h5555;
    bus.cpu_dout   = 8'h77;
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_wr_n   = 1'b0;
    @(negedge clk);
    #1;
    check("mid_req_up", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_wait_n", 32'(bus.cpu_wait_n), 32'd1);
    @(negedge clk);
    #1;
    check("mid_req_drop", 32'(bus.mem_req), 32'd0);
    check("mid_log", 32'(bus.log_valid), 32'd0);
    check("mid_timeout", 32'(bus.bus_timeout), 32'd0);
    check("mid_overflow", 32'(bus.log_overflow), 32'd0);
    check("mid_di", 32'(bus.cpu_di), 32'hFF);
    idle_strobes();
    @(negedge clk);
    reset = 1'b0;
    exp_di  = 8'hFF;
    exp_to  = 1'b0;
    exp_ovf = 1'b0;
    exp_log.delete();

    // Load a known value into cpu_di, then refresh and interrupt-ack cycles.
    bus_cycle(1'b0, 1'b0, 16'h0000, 8'h00, 1, 0, 1'b0);
    @(negedge clk);
    bus.cpu_a      = 16'h0080;
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_rfsh_n = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rfsh_req", 32'(bus.mem_req), 32'd0);
      check("rfsh_wait_n", 32'(bus.cpu_wait_n), 32'd1);
      @(negedge clk);
    end
    idle_strobes();
    bus.cpu_iorq_n = 1'b0;
    bus.cpu_m1_n   = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("inta_req", 32'(bus.mem_req), 32'd0);
      check("inta_wait_n", 32'(bus.cpu_wait_n), 32'd1);
      @(negedge clk);
    end
    idle_strobes();
    exp_di = 8'hFF;
    #1;
    check("inta_di", 32'(bus.cpu_di), 32'(exp_di));
    check("inta_log", 32'(bus.log_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
